// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// datapath mux selects and the decoded instruction-class record.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // One-hot instruction class plus a variant bit that picks the second
    // member of each pair: sw (vs lw), bne (vs beq), jal (vs j), ori (vs addi).
    typedef struct packed {
        logic r_type;
        logic mem;
        logic branch;
        logic jump;
        logic imm;
        logic illegal;
        logic variant;
    } op_class_t;

    // Branch resolution: beq takes on zero, bne takes on non-zero.
    function automatic logic branch_taken(input logic is_bne, input logic zero_flag);
        return is_bne ? ~zero_flag : zero_flag;
    endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// Opcode classifier: maps IR[31:26] onto one instruction class and flags
// anything the control FSM does not implement.
module ctrl_opdecode
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode_i,
    output op_class_t      cls_o
);

    // Purely combinational classification; unknown opcodes fall to illegal.
    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_RTYPE: cls_o.r_type = 1'b1;
            OP_LW:    cls_o.mem    = 1'b1;
            OP_SW: begin
                cls_o.mem     = 1'b1;
                cls_o.variant = 1'b1;
            end
            OP_BEQ:   cls_o.branch = 1'b1;
            OP_BNE: begin
                cls_o.branch  = 1'b1;
                cls_o.variant = 1'b1;
            end
            OP_J:     cls_o.jump   = 1'b1;
            OP_JAL: begin
                cls_o.jump    = 1'b1;
                cls_o.variant = 1'b1;
            end
            OP_ADDI:  cls_o.imm    = 1'b1;
            OP_ORI: begin
                cls_o.imm     = 1'b1;
                cls_o.variant = 1'b1;
            end
            default:  cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback one state per cycle and drives every mux
// select and write enable of the datapath.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           reg_write,
    output logic [1:0]     mem_to_reg,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic           ext_zero,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_source,
    output logic           instr_done,
    output logic           illegal_op
);

    logic [STW-1:0] state_q, state_d;
    logic           variant_q, variant_d;
    op_class_t      cls;

    ctrl_opdecode #(
        .OPW (OPW)
    ) u_opdecode (
        .opcode_i (opcode),
        .cls_o    (cls)
    );

    // State and latched instruction variant; reset aborts any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            variant_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            variant_q <= variant_d;
        end
    end

    // Next-state and output decode; all outputs default low, so RESET and
    // unused encodings drive nothing.
    always_comb begin
        state_d    = S_RESET;
        variant_d  = variant_q;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        ext_zero   = 1'b0;
        alu_op     = ALU_ADD;
        pc_source  = PCS_ALU;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            // PC+4 computed while memory returns the instruction; PC and IR
            // load together on the cycle the read completes.
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end

            // Branch target precomputed into ALUOut regardless of class.
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH;
                variant_d = cls.variant;
                if (cls.r_type) begin
                    state_d = S_EXEC_R;
                end else if (cls.mem) begin
                    state_d = S_MEM_ADDR;
                end else if (cls.branch) begin
                    state_d = S_BRANCH;
                end else if (cls.jump) begin
                    state_d = S_JUMP;
                end else if (cls.imm) begin
                    state_d = S_EXEC_I;
                end else begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_op    = ALU_FUNCT;
                state_d   = S_WB_R;
            end

            S_WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = M2R_ALUOUT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            // variant_q set means ori: zero-extended immediate with OR.
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = variant_q ? ALU_OR : ALU_ADD;
                ext_zero  = variant_q;
                state_d   = S_WB_I;
            end

            S_WB_I: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_ALUOUT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = variant_q ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? S_WB_MEM : S_MEM_RD;
            end

            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            // Store completes on the cycle memory accepts it.
            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEM_WR;
            end

            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REGB;
                alu_op     = ALU_SUB;
                pc_source  = PCS_ALUOUT;
                pc_en      = branch_taken(variant_q, zero);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            // jal links PC into $31; the datapath forces the destination.
            S_JUMP: begin
                pc_source  = PCS_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                if (variant_q) begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_PC;
                    reg_dst    = 1'b1;
                end
                state_d    = S_FETCH;
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction cycle model.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } out_t;

    typedef enum int {K_R, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_write;
    logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
    logic       alu_src_a, ext_zero, instr_done, illegal_op;

    int n_chk = 0;
    int n_err = 0;
    int n_cyc;
    int done_cnt;
    int done_at;

    multicycle_control #(.OPW(6), .STW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] opc(input kind_e k);
        case (k)
            K_R:     return 6'b000000;
            K_ADDI:  return 6'b001000;
            K_ORI:   return 6'b001101;
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_BEQ:   return 6'b000100;
            K_BNE:   return 6'b000101;
            K_J:     return 6'b000010;
            K_JAL:   return 6'b000011;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        for (int k = 0; k < 9; k++) if (opc(kind_e'(k)) == op) return 1'b1;
        return 1'b0;
    endfunction

    // Instruction length with memory always ready, as the latency table states.
    function automatic int base_lat(input kind_e k);
        case (k)
            K_LW:                    return 5;
            K_R, K_ADDI, K_ORI, K_SW: return 4;
            K_ILL:                   return 2;
            default:                 return 3;
        endcase
    endfunction

    // One cycle: drive inputs, sample mid-cycle, compare, advance past the edge.
    task automatic cyc(input out_t e, input logic mr, input logic z, input string tag);
        out_t o;
        mem_ready = mr;
        zero      = z;
        @(negedge clk);
        o = '{pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_write, mem_to_reg,
              alu_src_a, alu_src_b, ext_zero, alu_op, pc_source, instr_done, illegal_op};
        check(tag, 32'(o), 32'(e));
        n_cyc++;
        if (o.instr_done) begin
            done_cnt++;
            done_at = n_cyc;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic out_t fetch_exp(input logic rdy);
        out_t e = '0;
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = rdy;
        e.pc_en     = rdy;
        return e;
    endfunction

    // Full instruction from FETCH: fw fetch stalls, mw memory stalls, zb zero in BRANCH.
    task automatic run_instr(input kind_e k, input logic [5:0] op, input int fw, input int mw,
                             input logic zb);
        out_t e;
        n_cyc = 0; done_cnt = 0; done_at = 0;
        opcode = 6'($urandom);
        for (int i = 0; i < fw; i++) cyc(fetch_exp(1'b0), 1'b0, rb(), "fetch_wait");
        cyc(fetch_exp(1'b1), 1'b1, rb(), "fetch");
        opcode = op;
        e = '0; e.alu_src_b = 2'b11;
        if (k == K_ILL) begin e.illegal_op = 1'b1; e.instr_done = 1'b1; end
        cyc(e, rb(), rb(), "decode");
        case (k)
            K_R: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                cyc(e, rb(), rb(), "exec_r");
                e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
                cyc(e, rb(), rb(), "wb_r");
            end
            K_ADDI, K_ORI: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                e.alu_op = (k == K_ORI) ? 2'b11 : 2'b00; e.ext_zero = (k == K_ORI);
                cyc(e, rb(), rb(), "exec_i");
                e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1;
                cyc(e, rb(), rb(), "wb_i");
            end
            K_LW, K_SW: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                cyc(e, rb(), rb(), "mem_addr");
                e = '0; e.i_or_d = 1'b1;
                if (k == K_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                for (int i = 0; i < mw; i++) cyc(e, 1'b0, rb(), "mem_wait");
                if (k == K_SW) e.instr_done = 1'b1;
                cyc(e, 1'b1, rb(), "mem_done");
                if (k == K_LW) begin
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
                    cyc(e, rb(), rb(), "wb_mem");
                end
            end
            K_BEQ, K_BNE: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
                e.pc_en = (k == K_BEQ) ? zb : ~zb; e.instr_done = 1'b1;
                cyc(e, rb(), zb, "branch");
            end
            K_J, K_JAL: begin
                e = '0; e.pc_source = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1;
                if (k == K_JAL) begin e.reg_write = 1'b1; e.mem_to_reg = 2'b10; e.reg_dst = 1'b1; end
                cyc(e, rb(), rb(), "jump");
            end
            default: ;
        endcase
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("latency", 32'(done_at), 32'(base_lat(k) + fw + ((k == K_LW || k == K_SW) ? mw : 0)));
    endtask

    initial begin
        out_t e;
        kind_e k;
        logic [5:0] op;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc('0, rb(), rb(), "reset_hold");
        rst = 1'b0;
        cyc('0, rb(), rb(), "reset_exit");

        run_instr(K_R,    opc(K_R),    0, 0, 1'b0);
        run_instr(K_LW,   opc(K_LW),   0, 2, 1'b0);
        run_instr(K_BEQ,  opc(K_BEQ),  0, 0, 1'b1);
        run_instr(K_BNE,  opc(K_BNE),  0, 0, 1'b1);
        run_instr(K_BEQ,  opc(K_BEQ),  1, 0, 1'b0);
        run_instr(K_JAL,  opc(K_JAL),  0, 0, 1'b0);
        run_instr(K_ILL,  6'b111111,   0, 0, 1'b0);
        run_instr(K_ADDI, opc(K_ADDI), 0, 0, 1'b0);
        run_instr(K_ORI,  opc(K_ORI),  2, 0, 1'b0);
        run_instr(K_SW,   opc(K_SW),   0, 1, 1'b0);
        run_instr(K_J,    opc(K_J),    0, 0, 1'b0);

        // Reset held three edges while lw is stalled in its memory read.
        n_cyc = 0;
        cyc(fetch_exp(1'b1), 1'b1, 1'b0, "rst_fetch");
        opcode = opc(K_LW);
        e = '0; e.alu_src_b = 2'b11;
        cyc(e, 1'b0, 1'b0, "rst_decode");
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cyc(e, 1'b0, 1'b0, "rst_addr");
        e = '0; e.i_or_d = 1'b1; e.mem_read = 1'b1;
        rst = 1'b1;
        cyc(e, 1'b0, 1'b0, "rst_memrd");
        cyc('0, 1'b1, 1'b1, "rst_zero1");
        cyc('0, 1'b1, 1'b1, "rst_zero2");
        rst = 1'b0;
        cyc('0, 1'b1, 1'b1, "rst_zero3");
        run_instr(K_R, opc(K_R), 0, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            k = kind_e'($urandom_range(0, 9));
            op = opc(k);
            if (k == K_ILL) begin
                do op = 6'($urandom); while (is_legal(op));
            end
            run_instr(k, op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
